// File: rtl/mult_switch_mb_pkg.sv
// mult_switch_pkg: shared constants and helpers for the multi-entry multiplier
// switch. It provides the default widths, the entry-index width derivation and
// the product width conversion (sign-extend or truncate).
package mult_switch_pkg;

  localparam int DEF_IN_W        = 16;
  localparam int DEF_OUT_W       = 32;
  localparam int DEF_BUF_DEPTH   = 4;
  localparam int DEF_PIPE_STAGES = 2;

  // Widest intermediate product the conversion helper handles.
  localparam int MAX_W = 64;

  // Entry index width for a buffer of 'depth' entries. The width is never 0.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Sign-extends a prod_w-bit two's complement product to MAX_W bits. The
  // caller keeps the low OUT bits of the result. If OUT >= prod_w, this gives
  // sign extension. If OUT < prod_w, this gives truncation to the low bits.
  function automatic logic [MAX_W-1:0] fit_product(input logic [MAX_W-1:0] prod,
                                                   input int               prod_w);
    logic [MAX_W-1:0] res;
    res = prod;
    for (int b = 0; b < MAX_W; b++) begin
      if (b >= prod_w) res[b] = prod[prod_w-1];
    end
    return res;
  endfunction

endpackage

// File: rtl/mult_switch_mb_if.sv
// mult_switch_mb_if: beat/handshake bundle of the multiplier switch.
//   i_valid/i_data/i_stationary/i_idx : input beat (write or stream)
//   i_clear                           : invalidate all buffer entries
//   i_stall / o_ready                 : downstream back-pressure, o_ready = ~i_stall
//   o_valid/o_data/o_idx              : product and the entry that produced it
//   o_drop                            : stream beat hit an invalid entry
// The master modport is the upstream/downstream environment.
// The slave modport is the switch itself.
interface mult_switch_mb_if #(
  parameter int IN_DATA_TYPE  = 16,
  parameter int OUT_DATA_TYPE = 32,
  parameter int IDX_W         = 2
);
  logic                            i_valid;
  logic signed [IN_DATA_TYPE-1:0]  i_data;
  logic                            i_stationary;
  logic [IDX_W-1:0]                i_idx;
  logic                            i_clear;
  logic                            i_stall;
  logic                            o_ready;
  logic                            o_valid;
  logic signed [OUT_DATA_TYPE-1:0] o_data;
  logic [IDX_W-1:0]                o_idx;
  logic                            o_drop;

  modport master (
    output i_valid, i_data, i_stationary, i_idx, i_clear, i_stall,
    input  o_ready, o_valid, o_data, o_idx, o_drop
  );

  modport slave (
    input  i_valid, i_data, i_stationary, i_idx, i_clear, i_stall,
    output o_ready, o_valid, o_data, o_idx, o_drop
  );
endinterface

// File: rtl/mult_switch_mb_pipelined_int_multiplier.sv
// pipelined_int_multiplier: signed multiplier with a PIPE_STAGES-deep
// valid/product/tag chain. The whole chain advances only when i_en is high.
//   CLK, rst_n      : clock, asynchronous active-low reset
//   i_en            : advance enable (~stall)
//   i_valid/i_a/i_b : issue a * b this cycle
//   i_tag           : side-band carried alongside the product
//   o_valid/o_p     : product leaving the last stage
//   o_tag           : tag leaving the last stage
module pipelined_int_multiplier
  import mult_switch_pkg::*;
#(
  parameter int IN_DATA_TYPE  = DEF_IN_W,
  parameter int OUT_DATA_TYPE = DEF_OUT_W,
  parameter int PIPE_STAGES   = DEF_PIPE_STAGES,
  parameter int TAG_W         = 2
) (
  input  logic                            CLK,
  input  logic                            rst_n,
  input  logic                            i_en,
  input  logic                            i_valid,
  input  logic signed [IN_DATA_TYPE-1:0]  i_a,
  input  logic signed [IN_DATA_TYPE-1:0]  i_b,
  input  logic [TAG_W-1:0]                i_tag,
  output logic                            o_valid,
  output logic signed [OUT_DATA_TYPE-1:0] o_p,
  output logic [TAG_W-1:0]                o_tag
);
  localparam int PROD_W = 2 * IN_DATA_TYPE;

  logic signed [PROD_W-1:0]        full_prod;
  logic [MAX_W-1:0]                wide_prod;
  logic [PIPE_STAGES-1:0]          vld_d, vld_q;
  logic signed [OUT_DATA_TYPE-1:0] p_d   [PIPE_STAGES];
  logic signed [OUT_DATA_TYPE-1:0] p_q   [PIPE_STAGES];
  logic [TAG_W-1:0]                tag_d [PIPE_STAGES];
  logic [TAG_W-1:0]                tag_q [PIPE_STAGES];

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned. This prevents inferred latches.
    full_prod = PROD_W'(i_a) * PROD_W'(i_b);
    wide_prod = fit_product(MAX_W'(full_prod), PROD_W);
    vld_d     = vld_q;
    p_d       = p_q;
    tag_d     = tag_q;
    if (i_en) begin
      vld_d[0] = i_valid;
      p_d[0]   = wide_prod[OUT_DATA_TYPE-1:0];
      tag_d[0] = i_tag;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        vld_d[s] = vld_q[s-1];
        p_d[s]   = p_q[s-1];
        tag_d[s] = tag_q[s-1];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        p_q[s]   <= '0;
        tag_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      p_q   <= p_d;
      tag_q <= tag_d;
    end
  end

  assign o_valid = vld_q[PIPE_STAGES-1];
  assign o_p     = p_q[PIPE_STAGES-1];
  assign o_tag   = tag_q[PIPE_STAGES-1];

endmodule

// File: rtl/mult_switch_mb.sv
// mult_switch_mb: leaf multiplier switch with BUF_DEPTH stationary entries.
// A stationary beat writes an entry and marks it valid.
// A stream beat multiplies i_data by the selected entry, if that entry is
// valid; otherwise the beat is dropped and o_drop pulses.
//   CLK, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mult_switch_mb_if (beats, clear, stall, products)
module mult_switch_mb
  import mult_switch_pkg::*;
#(
  parameter int IN_DATA_TYPE  = DEF_IN_W,
  parameter int OUT_DATA_TYPE = DEF_OUT_W,
  parameter int BUF_DEPTH     = DEF_BUF_DEPTH,
  parameter int PIPE_STAGES   = DEF_PIPE_STAGES,
  parameter int IDX_W         = idx_width(BUF_DEPTH)
) (
  input logic             CLK,
  input logic             rst_n,
  mult_switch_mb_if.slave bus
);
  logic signed [IN_DATA_TYPE-1:0] ent_d [BUF_DEPTH];
  logic signed [IN_DATA_TYPE-1:0] ent_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]           vld_d, vld_q;
  logic                           drop_d, drop_q;
  logic                           accept;
  logic                           issue;
  logic signed [IN_DATA_TYPE-1:0] rd_data;

  always_comb begin
    accept  = bus.i_valid & ~bus.i_stall;
    // Stream beats read the registered entry. Stream beats therefore use the
    // pre-clear contents and cannot see a same-cycle write.
    rd_data = ent_q[bus.i_idx];
    issue   = accept & ~bus.i_stationary & vld_q[bus.i_idx];
    drop_d  = accept & ~bus.i_stationary & ~vld_q[bus.i_idx];
    ent_d   = ent_q;
    vld_d   = vld_q;
    if (!bus.i_stall && bus.i_clear) vld_d = '0;
    // Applied after the clear, so a simultaneous write leaves its entry valid.
    if (accept && bus.i_stationary) begin
      ent_d[bus.i_idx] = bus.i_data;
      vld_d[bus.i_idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this register file is small, and its contents must read as zero after reset. It is therefore reset explicitly and is not inferred as RAM.
      for (int i = 0; i < BUF_DEPTH; i++) ent_q[i] <= '0;
      vld_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      ent_q  <= ent_d;
      vld_q  <= vld_d;
      drop_q <= drop_d;
    end
  end

  pipelined_int_multiplier #(
    .IN_DATA_TYPE (IN_DATA_TYPE),
    .OUT_DATA_TYPE(OUT_DATA_TYPE),
    .PIPE_STAGES  (PIPE_STAGES),
    .TAG_W        (IDX_W)
  ) u_mult (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .i_en   (~bus.i_stall),
    .i_valid(issue),
    .i_a    (bus.i_data),
    .i_b    (rd_data),
    .i_tag  (bus.i_idx),
    .o_valid(bus.o_valid),
    .o_p    (bus.o_data),
    .o_tag  (bus.o_idx)
  );

  assign bus.o_ready = ~bus.i_stall;
  assign bus.o_drop  = drop_q;

endmodule

// File: tb/tb_mult_switch_mb.sv
// tb_mult_switch_mb: directed scenarios plus randomized beats, driven in
// parallel into a 32-bit-output and a 16-bit-output instance. Both are compared
// against a queue-based model of entries, valid bits and product due times.
module tb_mult_switch_mb;
  import mult_switch_pkg::*;

  localparam int IN_W   = 16;
  localparam int OUT_W  = 32;
  localparam int OUT16  = 16;
  localparam int DEPTH  = 4;
  localparam int STAGES = 2;
  localparam int IDX_W  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_switch_mb_if #(.IN_DATA_TYPE(IN_W), .OUT_DATA_TYPE(OUT_W), .IDX_W(IDX_W)) bus ();
  mult_switch_mb_if #(.IN_DATA_TYPE(IN_W), .OUT_DATA_TYPE(OUT16), .IDX_W(IDX_W)) bus16 ();

  mult_switch_mb #(.IN_DATA_TYPE(IN_W), .OUT_DATA_TYPE(OUT_W), .BUF_DEPTH(DEPTH),
                   .PIPE_STAGES(STAGES)) u_dut (.CLK(clk), .rst_n(rst_n), .bus(bus));
  mult_switch_mb #(.IN_DATA_TYPE(IN_W), .OUT_DATA_TYPE(OUT16), .BUF_DEPTH(DEPTH),
                   .PIPE_STAGES(STAGES)) u_dut16 (.CLK(clk), .rst_n(rst_n), .bus(bus16));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state. Each product is due when the count of unstalled edges reaches
  // the count at issue plus the pipeline depth.
  typedef struct {
    int     due;
    longint val;
    int     idx;
  } exp_t;

  shortint m_ent [DEPTH];
  bit      m_vld [DEPTH];
  bit      m_drop;
  int      ucount;
  exp_t    exp_q [$];

  task automatic model_reset();
    exp_q.delete();
    foreach (m_vld[i]) begin
      m_vld[i] = 1'b0;
      m_ent[i] = 16'sd0;
    end
    m_drop = 1'b0;
  endtask

  task automatic model_edge(input bit v, input bit st, input int idx, input int data,
                            input bit clr, input bit stl);
    exp_t e;
    bit   nd;
    nd = 1'b0;
    if (!stl) begin
      if (v && !st) begin
        if (m_vld[idx]) begin
          e.due = ucount + STAGES;
          e.val = longint'(shortint'(data)) * longint'(m_ent[idx]);
          e.idx = idx;
          exp_q.push_back(e);
        end else begin
          nd = 1'b1;
        end
      end
      if (clr) foreach (m_vld[i]) m_vld[i] = 1'b0;
      if (v && st) begin
        m_ent[idx] = shortint'(data);
        m_vld[idx] = 1'b1;
      end
      ucount++;
    end
    m_drop = nd;
  endtask

  task automatic drive(input bit v, input bit st, input int idx, input int data,
                       input bit clr, input bit stl);
    bus.i_valid        = v;    bus16.i_valid      = v;
    bus.i_stationary   = st;   bus16.i_stationary = st;
    bus.i_idx          = IDX_W'(idx);
    bus16.i_idx        = IDX_W'(idx);
    bus.i_data         = IN_W'(data);
    bus16.i_data       = IN_W'(data);
    bus.i_clear        = clr;  bus16.i_clear      = clr;
    bus.i_stall        = stl;  bus16.i_stall      = stl;
  endtask

  task automatic check_outputs(input bit stl);
    bit     ev;
    longint v;
    while (exp_q.size() > 0 && exp_q[0].due < ucount) void'(exp_q.pop_front());
    ev = (exp_q.size() > 0) && (exp_q[0].due == ucount);
    check("o_ready",    64'(bus.o_ready),   64'(!stl));
    check("o_ready16",  64'(bus16.o_ready), 64'(!stl));
    check("o_valid",    64'(bus.o_valid),   64'(ev));
    check("o_valid16",  64'(bus16.o_valid), 64'(ev));
    check("o_drop",     64'(bus.o_drop),    64'(m_drop));
    check("o_drop16",   64'(bus16.o_drop),  64'(m_drop));
    if (ev) begin
      v = exp_q[0].val;
      check("o_data",   64'($unsigned(bus.o_data)),   64'(v[31:0]));
      check("o_data16", 64'($unsigned(bus16.o_data)), 64'(v[15:0]));
      check("o_idx",    64'(bus.o_idx),   64'(exp_q[0].idx));
      check("o_idx16",  64'(bus16.o_idx), 64'(exp_q[0].idx));
    end
  endtask

  // One cycle: drive just after the rising edge, check at the falling edge,
  // then advance the model at the rising edge.
  task automatic step(input bit v, input bit st, input int idx, input int data,
                      input bit clr, input bit stl);
    drive(v, st, idx, data, clr, stl);
    @(negedge clk);
    check_outputs(stl);
    @(posedge clk);
    model_edge(v, st, idx, data, clr, stl);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_o_valid"},   64'(bus.o_valid),               64'(0));
    check({tag, "_o_valid16"}, 64'(bus16.o_valid),             64'(0));
    check({tag, "_o_drop"},    64'(bus.o_drop),                64'(0));
    check({tag, "_o_data"},    64'($unsigned(bus.o_data)),     64'(0));
    check({tag, "_o_data16"},  64'($unsigned(bus16.o_data)),   64'(0));
    check({tag, "_o_idx"},     64'(bus.o_idx),                 64'(0));
  endtask

  // Asserts reset away from any clock edge. The outputs must clear
  // immediately, before the next edge arrives.
  task automatic reset_mid();
    rst_n = 1'b0;
    #1;
    check("rst_mid_o_valid",   64'(bus.o_valid),   64'(0));
    check("rst_mid_o_valid16", 64'(bus16.o_valid), 64'(0));
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_edge(0, 0, 0, 0, 0, 0);
    #1;
  endtask

  function automatic int pick_data();
    case ($urandom_range(0, 5))
      0:       return -32768;
      1:       return 32767;
      2:       return -1;
      3:       return 0;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    bit rv, rst_b, rclr, rstl;
    int ridx, rdata;

    ucount = 0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    model_edge(0, 0, 0, 0, 0, 0);
    #1;

    // Stream on an invalid entry after reset: drop, no product.
    step(1, 0, 1, 7, 0, 0);
    idle(3);

    // Basic: entry 2 = 3, stream 5 -> 15 on idx 2.
    step(1, 1, 2, 3, 0, 0);
    step(1, 0, 2, 5, 0, 0);
    idle(3);

    // Multi-entry and sign, streamed back-to-back.
    step(1, 1, 0, -2, 0, 0);
    step(1, 1, 1, 7, 0, 0);
    step(1, 1, 2, 32'h7FFF, 0, 0);
    step(1, 1, 3, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, i, -4, 0, 0);
    idle(3);

    // Write with clear: the written entry stays valid. Clear alone: drop.
    step(1, 1, 1, 9, 1, 0);
    step(1, 0, 1, 2, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 1, 2, 0, 0);
    idle(2);

    // Stall with a valid output presented. Beats offered during the stall are ignored.
    for (int i = 0; i < 4; i++) step(1, 1, i, i + 3, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, i, 10 + i, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, i, 99, 0, 1);
    idle(4);

    // Rewrite of the entry while its product is in flight.
    step(1, 1, 0, 2, 0, 0);
    step(1, 0, 0, 6, 0, 0);
    step(1, 1, 0, 10, 0, 0);
    step(1, 0, 0, 6, 0, 0);
    idle(3);

    // 0x0100 * 0x0100: 0x10000 on 32 bits, truncates to 0 on 16 bits.
    step(1, 1, 3, 32'h0100, 0, 0);
    step(1, 0, 3, 32'h0100, 0, 0);
    idle(3);

    // Reset with two products in flight, then the old entry must be invalid.
    step(1, 0, 3, 32'h0100, 0, 0);
    step(1, 0, 3, 32'h0100, 0, 0);
    reset_mid();
    step(1, 0, 3, 32'h0100, 0, 0);
    idle(2);

    // Randomized beats with clears and stalls mixed in.
    for (int n = 0; n < 600; n++) begin
      rv    = ($urandom_range(0, 99) < 80);
      rst_b = ($urandom_range(0, 99) < 30);
      rclr  = ($urandom_range(0, 99) < 4);
      rstl  = ($urandom_range(0, 99) < 20);
      ridx  = int'($urandom_range(0, DEPTH - 1));
      rdata = pick_data();
      step(rv, rst_b, ridx, rdata, rclr, rstl);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
